// File: rtl/i2c_bus_frontend_if.sv
// Pad-side and event-side signal bundle of the I2C bus front end.
// The slave modport is the front end itself; master is whoever drives the pads and controls.
interface i2c_bus_frontend_if;
   logic       ena;
   logic       filter_en;
   logic       scl_in;
   logic       sda_in;
   logic       glitch_clr;
   logic       scl_o;
   logic       sda_o;
   logic       scl_rise;
   logic       scl_fall;
   logic       start_det;
   logic       stop_det;
   logic       bus_busy;
   logic [7:0] glitch_cnt;

   modport slave (
      input  ena, filter_en, scl_in, sda_in, glitch_clr,
      output scl_o, sda_o, scl_rise, scl_fall, start_det, stop_det, bus_busy, glitch_cnt
   );

   modport master (
      output ena, filter_en, scl_in, sda_in, glitch_clr,
      input  scl_o, sda_o, scl_rise, scl_fall, start_det, stop_det, bus_busy, glitch_cnt
   );
endinterface

// File: rtl/i2c_bus_frontend.sv
// Synchronises and deglitches SCL/SDA pads, then derives SCL edge, START and STOP strobes,
// a bus-busy flag and a saturating count of rejected glitches.
module i2c_bus_frontend #(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 3
) (
   input logic               clk,
   input logic               rst_n,
   i2c_bus_frontend_if.slave bus
);

   localparam int                CNT_W    = $clog2(FILTER_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   typedef enum logic {BUS_IDLE, BUS_BUSY} bus_state_e;

   // Index 0 is SCL, index 1 is SDA throughout.
   logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
   logic [1:0][CNT_W-1:0]       fcnt_q, fcnt_d;
   logic [1:0]                  filt_q, filt_d;
   logic [1:0]                  prev_q, prev_d;
   logic [1:0]                  synced;
   logic [1:0]                  lvl;
   logic [1:0]                  glitch_evt;
   logic                        rise_q, rise_d;
   logic                        fall_q, fall_d;
   logic                        start_q, start_d;
   logic                        stop_q, stop_d;
   bus_state_e                  state_q, state_d;
   logic [7:0]                  glitch_cnt_q, glitch_cnt_d;

   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
      logic [8:0] sum;
      sum = {1'b0, a} + {7'b0, inc};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

   always_comb begin
      sync_d     = sync_q;
      fcnt_d     = '0;
      filt_d     = filt_q;
      synced     = '0;
      lvl        = '0;
      glitch_evt = '0;
      for (int i = 0; i < 2; i++) begin
         sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], (i == 0) ? bus.scl_in : bus.sda_in};
         synced[i] = sync_q[i][SYNC_STAGES-1];
         if (!bus.filter_en) begin
            filt_d[i] = synced[i];
         end else if (synced[i] != filt_q[i]) begin
            if (fcnt_q[i] == CNT_LAST) filt_d[i] = synced[i];
            else                       fcnt_d[i] = fcnt_q[i] + CNT_ONE;
         end else begin
            // A run of differing samples that ended early is a rejected glitch.
            glitch_evt[i] = (fcnt_q[i] != '0);
         end
         // Bypass exposes the synced node directly so its latency is just the sync chain.
         lvl[i] = bus.filter_en ? filt_q[i] : synced[i];
      end
   end

   always_comb begin
      prev_d  = lvl;
      rise_d  = bus.ena &  lvl[0] & ~prev_q[0];
      fall_d  = bus.ena & ~lvl[0] &  prev_q[0];
      // SCL must be stable high across both samples, so simultaneous SCL/SDA changes are ignored.
      start_d = bus.ena & lvl[0] & prev_q[0] & ~lvl[1] &  prev_q[1];
      stop_d  = bus.ena & lvl[0] & prev_q[0] &  lvl[1] & ~prev_q[1];

      state_d = state_q;
      if (!bus.ena)      state_d = BUS_IDLE;
      else if (start_q)  state_d = BUS_BUSY;
      else if (stop_q)   state_d = BUS_IDLE;

      glitch_cnt_d = bus.glitch_clr ? 8'd0
                   : sat_add8(glitch_cnt_q, {1'b0, glitch_evt[0]} + {1'b0, glitch_evt[1]});
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q       <= '1;
         fcnt_q       <= '0;
         filt_q       <= 2'b11;
         prev_q       <= 2'b11;
         rise_q       <= 1'b0;
         fall_q       <= 1'b0;
         start_q      <= 1'b0;
         stop_q       <= 1'b0;
         state_q      <= BUS_IDLE;
         glitch_cnt_q <= 8'd0;
      end else begin
         sync_q       <= sync_d;
         fcnt_q       <= fcnt_d;
         filt_q       <= filt_d;
         prev_q       <= prev_d;
         rise_q       <= rise_d;
         fall_q       <= fall_d;
         start_q      <= start_d;
         stop_q       <= stop_d;
         state_q      <= state_d;
         glitch_cnt_q <= glitch_cnt_d;
      end
   end

   assign bus.scl_o      = lvl[0];
   assign bus.sda_o      = lvl[1];
   assign bus.scl_rise   = rise_q;
   assign bus.scl_fall   = fall_q;
   assign bus.start_det  = start_q;
   assign bus.stop_det   = stop_q;
   assign bus.bus_busy   = (state_q == BUS_BUSY);
   assign bus.glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_i2c_bus_frontend.sv
// Directed bench for i2c_bus_frontend: reset, START/STOP, glitch rejection and saturation,
// bypass, simultaneous edges, repeated START, enable drop and mid-transfer reset.
module tb_i2c_bus_frontend;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;
   int   n_start, n_stop, n_rise, n_fall, n_sda_low;
   int   s_start, s_stop, s_rise, s_fall, s_sda_low;

   i2c_bus_frontend_if bus();

   i2c_bus_frontend #(.SYNC_STAGES(2), .FILTER_CYCLES(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      n_start = 0; n_stop = 0; n_rise = 0; n_fall = 0; n_sda_low = 0;
   end

   always @(negedge clk) begin
      if (bus.start_det === 1'b1) n_start++;
      if (bus.stop_det  === 1'b1) n_stop++;
      if (bus.scl_rise  === 1'b1) n_rise++;
      if (bus.scl_fall  === 1'b1) n_fall++;
      if (bus.sda_o     === 1'b0) n_sda_low++;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic snap();
      s_start = n_start; s_stop = n_stop; s_rise = n_rise; s_fall = n_fall; s_sda_low = n_sda_low;
   endtask

   task automatic sda_glitch();
      bus.sda_in = 1'b0;
      tick(2);
      bus.sda_in = 1'b1;
      tick(4);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n          = 1'b0;
      bus.ena        = 1'b1;
      bus.filter_en  = 1'b1;
      bus.scl_in     = 1'b1;
      bus.sda_in     = 1'b1;
      bus.glitch_clr = 1'b0;
      tick(3);

      // Reset state with idle lines
      chk("rst_scl_o", bus.scl_o, 1);
      chk("rst_sda_o", bus.sda_o, 1);
      chk("rst_strobes", {bus.scl_rise, bus.scl_fall, bus.start_det, bus.stop_det}, 0);
      chk("rst_busy", bus.bus_busy, 0);
      chk("rst_glitch", bus.glitch_cnt, 0);
      rst_n = 1'b1;
      snap();
      tick(20);
      chk("idle_no_strobes", (n_start - s_start) + (n_stop - s_stop) + (n_rise - s_rise) + (n_fall - s_fall), 0);
      chk("idle_busy", bus.bus_busy, 0);

      // START then STOP through the filter
      snap();
      bus.sda_in = 1'b0;
      tick(4);
      chk("start_lat_sda_hi", bus.sda_o, 1);
      tick(1);
      chk("start_lat_sda_lo", bus.sda_o, 0);
      chk("start_early", bus.start_det, 0);
      tick(1);
      chk("start_det", bus.start_det, 1);
      chk("busy_before", bus.bus_busy, 0);
      tick(1);
      chk("start_one_clk", bus.start_det, 0);
      chk("busy_set", bus.bus_busy, 1);
      bus.sda_in = 1'b1;
      tick(5);
      chk("stop_early", bus.stop_det, 0);
      tick(1);
      chk("stop_det", bus.stop_det, 1);
      tick(1);
      chk("stop_one_clk", bus.stop_det, 0);
      chk("busy_clr", bus.bus_busy, 0);
      chk("start_count", n_start - s_start, 1);

      // Glitch rejection and saturation
      snap();
      sda_glitch();
      chk("glitch_sda_stays", n_sda_low - s_sda_low, 0);
      chk("glitch_no_start", n_start - s_start, 0);
      chk("glitch_cnt1", bus.glitch_cnt, 1);
      for (int i = 0; i < 299; i++) sda_glitch();
      chk("glitch_sat", bus.glitch_cnt, 255);
      bus.sda_in = 1'b0;
      tick(2);
      bus.sda_in = 1'b1;
      tick(2);
      bus.glitch_clr = 1'b1;
      tick(1);
      bus.glitch_clr = 1'b0;
      chk("glitch_clr_prio", bus.glitch_cnt, 0);
      tick(1);
      sda_glitch();
      chk("glitch_after_clr", bus.glitch_cnt, 1);
      snap();
      bus.scl_in = 1'b0;
      bus.sda_in = 1'b0;
      tick(2);
      bus.scl_in = 1'b1;
      bus.sda_in = 1'b1;
      tick(4);
      chk("glitch_both_plus2", bus.glitch_cnt, 3);
      chk("glitch_both_nofall", n_fall - s_fall, 0);

      // Bypass: one-clock SDA pulse passes straight through
      bus.filter_en = 1'b0;
      tick(2);
      bus.sda_in = 1'b0;
      tick(1);
      bus.sda_in = 1'b1;
      chk("byp_sda_p1", bus.sda_o, 1);
      tick(1);
      chk("byp_sda_low", bus.sda_o, 0);
      tick(1);
      chk("byp_sda_back", bus.sda_o, 1);
      chk("byp_start", bus.start_det, 1);
      tick(1);
      chk("byp_stop", bus.stop_det, 1);
      chk("byp_glitch_same", bus.glitch_cnt, 3);
      bus.filter_en = 1'b1;
      tick(4);

      // Simultaneous SCL/SDA changes
      snap();
      bus.scl_in = 1'b0;
      bus.sda_in = 1'b0;
      tick(6);
      chk("sim_fall", bus.scl_fall, 1);
      chk("sim_no_start", bus.start_det, 0);
      tick(2);
      bus.scl_in = 1'b1;
      bus.sda_in = 1'b1;
      tick(6);
      chk("sim_rise", bus.scl_rise, 1);
      chk("sim_no_stop", bus.stop_det, 0);
      tick(2);
      chk("sim_no_events", (n_start - s_start) + (n_stop - s_stop), 0);

      // Repeated START while busy
      snap();
      bus.sda_in = 1'b0;
      tick(7);
      chk("rs_busy1", bus.bus_busy, 1);
      bus.scl_in = 1'b0;
      tick(7);
      bus.sda_in = 1'b1;
      tick(7);
      bus.scl_in = 1'b1;
      tick(7);
      chk("rs_busy_hold", bus.bus_busy, 1);
      bus.sda_in = 1'b0;
      tick(6);
      chk("rs_start", bus.start_det, 1);
      tick(1);
      chk("rs_busy2", bus.bus_busy, 1);
      chk("rs_start_cnt", n_start - s_start, 2);
      chk("rs_stop_cnt", n_stop - s_stop, 0);

      // Enable dropped while busy
      snap();
      bus.ena = 1'b0;
      tick(1);
      chk("ena_busy_clr", bus.bus_busy, 0);
      bus.scl_in = 1'b0;
      tick(8);
      chk("ena_scl_follows", bus.scl_o, 0);
      chk("ena_no_fall", n_fall - s_fall, 0);
      bus.ena = 1'b1;
      bus.scl_in = 1'b1;
      tick(7);
      bus.sda_in = 1'b1;
      tick(7);
      bus.sda_in = 1'b0;
      tick(7);
      bus.scl_in = 1'b0;
      tick(7);
      chk("mid_busy", bus.bus_busy, 1);

      // Reset mid-transfer
      rst_n = 1'b0;
      tick(1);
      chk("mrst_scl_o", bus.scl_o, 1);
      chk("mrst_sda_o", bus.sda_o, 1);
      chk("mrst_busy", bus.bus_busy, 0);
      chk("mrst_glitch", bus.glitch_cnt, 0);
      chk("mrst_strobes", {bus.scl_rise, bus.scl_fall, bus.start_det, bus.stop_det}, 0);
      bus.scl_in = 1'b1;
      bus.sda_in = 1'b1;
      tick(1);
      rst_n = 1'b1;
      snap();
      tick(10);
      chk("mrst_no_strobes", (n_start - s_start) + (n_stop - s_stop) + (n_rise - s_rise) + (n_fall - s_fall), 0);
      chk("mrst_scl_idle", bus.scl_o, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
